// File: rtl/delay_tap_scan_if.sv
// -----------------------------------------------------------------------------
// delay_tap_scan_if
// Purpose : delay_config bus between the tap-scan calibration controller and
//           the cascaded IDELAY/ODELAY pair.
// Signals : op     [1:0] - 0 = hold, 1 = load value (2 and 3 unused)
//           select       - delay element select, constant per instance
//           value  [8:0] - tap value applied when op == 1
// Modports: master - driven by the calibration controller
//           slave  - consumed by the delay pair (or a monitor)
// -----------------------------------------------------------------------------
interface delay_tap_scan_if;
   logic [1:0] op;
   logic       select;
   logic [8:0] value;

   modport master (output op, output select, output value);
   modport slave  (input  op, input  select, input  value);
endinterface

// File: rtl/delay_tap_scan.sv
// -----------------------------------------------------------------------------
// delay_tap_scan
// Purpose : Per-bit deskew calibration. Sweeps every tap 0..MAX_TAP, dwells at
//           each tap comparing captured data with the training bit, tracks the
//           longest contiguous passing window and finally loads its floor
//           centre into the delay pair.
// Ports   : clk            - clock
//           clk__enable    - clock enable, all state advances only when high
//           reset_n        - asynchronous active-low reset
//           start          - begin calibration (honoured in IDLE or DONE)
//           data_sample    - delayed data captured downstream
//           data_expected  - training bit expected this cycle
//           delay_config   - op/select/value bus to the delay pair (master)
//           busy, done, success, result_tap, window_length - status
// -----------------------------------------------------------------------------
module delay_tap_scan #(
   parameter int unsigned MAX_TAP       = 511,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned DWELL_CYCLES  = 64,
   parameter int unsigned MIN_WINDOW    = 4,
   parameter logic        SELECT        = 1'b0
) (
   input  logic                     clk,
   input  logic                     clk__enable,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     data_sample,
   input  logic                     data_expected,
   delay_tap_scan_if.master         delay_config,
   output logic                     busy,
   output logic                     done,
   output logic                     success,
   output logic [8:0]               result_tap,
   output logic [9:0]               window_length
);

   localparam int unsigned CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_DWELL, S_EVAL, S_FINAL_LOAD, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [8:0]       tap_q, tap_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fail_flag_q, fail_flag_d;
   logic [8:0]       cur_start_q, cur_start_d;
   logic [9:0]       cur_len_q, cur_len_d;
   logic [8:0]       best_start_q, best_start_d;
   logic [9:0]       best_len_q, best_len_d;
   logic [1:0]       op_q, op_d;
   logic [8:0]       value_q, value_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             success_q, success_d;
   logic [8:0]       result_tap_q, result_tap_d;
   logic [9:0]       window_length_q, window_length_d;

   always_comb begin
      state_d         = state_q;
      tap_d           = tap_q;
      cnt_d           = cnt_q;
      fail_flag_d     = fail_flag_q;
      cur_start_d     = cur_start_q;
      cur_len_d       = cur_len_q;
      best_start_d    = best_start_q;
      best_len_d      = best_len_q;
      value_d         = value_q;
      busy_d          = busy_q;
      done_d          = done_q;
      success_d       = success_q;
      result_tap_d    = result_tap_q;
      window_length_d = window_length_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d      = S_LOAD;
               tap_d        = '0;
               cnt_d        = '0;
               fail_flag_d  = 1'b0;
               cur_start_d  = '0;
               cur_len_d    = '0;
               best_start_d = '0;
               best_len_d   = '0;
               busy_d       = 1'b1;
               done_d       = 1'b0;
               success_d    = 1'b0;
            end
         end
         S_LOAD: begin
            state_d = S_SETTLE;
            cnt_d   = '0;
         end
         S_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = S_DWELL;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DWELL: begin
            fail_flag_d = fail_flag_q | (data_sample != data_expected);
            if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = S_EVAL;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_EVAL: begin
            if (!fail_flag_q) begin
               // A run starts at this tap when none is open.
               if (cur_len_q == '0) begin
                  cur_start_d = tap_q;
               end
               cur_len_d = cur_len_q + 10'd1;
               // Strictly longer only, so ties keep the earliest window.
               if (cur_len_d > best_len_q) begin
                  best_start_d = cur_start_d;
                  best_len_d   = cur_len_d;
               end
            end else begin
               cur_len_d = '0;
            end
            fail_flag_d = 1'b0;
            if (tap_q == 9'(MAX_TAP)) begin
               // The result is decided from the trackers as updated by the
               // last tap, so a window touching MAX_TAP is included.
               state_d         = S_FINAL_LOAD;
               window_length_d = best_len_d;
               if (best_len_d >= 10'(MIN_WINDOW)) begin
                  result_tap_d = 9'(10'(best_start_d) + ((best_len_d - 10'd1) >> 1));
                  success_d    = 1'b1;
               end else begin
                  result_tap_d = '0;
                  success_d    = 1'b0;
               end
               value_d = result_tap_d;
            end else begin
               tap_d   = tap_q + 9'd1;
               state_d = S_LOAD;
            end
         end
         S_FINAL_LOAD: begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // op is registered together with the state, so it is high exactly for
      // the one enabled cycle spent in a load state.
      if (state_d == S_LOAD) begin
         value_d = tap_d;
      end
      op_d = ((state_d == S_LOAD) || (state_d == S_FINAL_LOAD)) ? 2'd1 : 2'd0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= S_IDLE;
         tap_q           <= '0;
         cnt_q           <= '0;
         fail_flag_q     <= 1'b0;
         cur_start_q     <= '0;
         cur_len_q       <= '0;
         best_start_q    <= '0;
         best_len_q      <= '0;
         op_q            <= 2'd0;
         value_q         <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         success_q       <= 1'b0;
         result_tap_q    <= '0;
         window_length_q <= '0;
      end else if (clk__enable) begin
         state_q         <= state_d;
         tap_q           <= tap_d;
         cnt_q           <= cnt_d;
         fail_flag_q     <= fail_flag_d;
         cur_start_q     <= cur_start_d;
         cur_len_q       <= cur_len_d;
         best_start_q    <= best_start_d;
         best_len_q      <= best_len_d;
         op_q            <= op_d;
         value_q         <= value_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         success_q       <= success_d;
         result_tap_q    <= result_tap_d;
         window_length_q <= window_length_d;
      end
   end

   assign delay_config.op     = op_q;
   assign delay_config.select = SELECT;
   assign delay_config.value  = value_q;
   assign busy                = busy_q;
   assign done                = done_q;
   assign success             = success_q;
   assign result_tap          = result_tap_q;
   assign window_length       = window_length_q;

endmodule

// File: tb/tb_delay_tap_scan.sv
// -----------------------------------------------------------------------------
// tb_delay_tap_scan
// Purpose : Directed self-checking bench for delay_tap_scan with
//           MAX_TAP=15, SETTLE_CYCLES=2, DWELL_CYCLES=4, MIN_WINDOW=3.
//           A helper process follows the load pulses to know the current tap
//           and dwell phase and drives data_sample to pass or fail per tap.
// -----------------------------------------------------------------------------
module tb_delay_tap_scan;

   localparam int MAX_TAP = 15;
   localparam int ST      = 2;
   localparam int DW      = 4;
   localparam int MINW    = 3;
   localparam int LAT     = (MAX_TAP + 1) * (ST + DW + 2) + 2;

   logic       clk           = 1'b0;
   logic       clk__enable   = 1'b1;
   logic       reset_n       = 1'b0;
   logic       start         = 1'b0;
   logic       data_sample   = 1'b0;
   logic       data_expected = 1'b0;
   logic       busy;
   logic       done;
   logic       success;
   logic [8:0] result_tap;
   logic [9:0] window_length;

   delay_tap_scan_if dcfg ();

   delay_tap_scan #(
      .MAX_TAP       (MAX_TAP),
      .SETTLE_CYCLES (ST),
      .DWELL_CYCLES  (DW),
      .MIN_WINDOW    (MINW),
      .SELECT        (1'b0)
   ) dut (
      .clk           (clk),
      .clk__enable   (clk__enable),
      .reset_n       (reset_n),
      .start         (start),
      .data_sample   (data_sample),
      .data_expected (data_expected),
      .delay_config  (dcfg),
      .busy          (busy),
      .done          (done),
      .success       (success),
      .result_tap    (result_tap),
      .window_length (window_length)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   logic [15:0] pass_mask  = 16'h0000;
   bit          split_mode = 1'b0;
   bit          en_toggle  = 1'b0;
   int          cur_tap    = 0;
   int          phase      = 0;
   int          en_cnt     = 0;
   bit          prev_op    = 1'b0;
   bit          dbl_op     = 1'b0;
   int          load_log[$];
   event        en_edge;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
      $display("[TB] %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Follows enabled edges: logs load pulses, tracks tap/phase, drives data.
   initial begin
      bit en_s;
      bit bad;
      forever begin
         @(posedge clk);
         en_s = clk__enable;
         #1;
         if (en_s && reset_n) begin
            en_cnt++;
            if (dcfg.op == 2'd1) begin
               load_log.push_back(int'(dcfg.value));
               if (prev_op) dbl_op = 1'b1;
               prev_op = 1'b1;
               cur_tap = int'(dcfg.value);
               phase   = 0;
            end else begin
               prev_op = 1'b0;
               phase++;
            end
            bad = !pass_mask[cur_tap[3:0]] || (split_mode && cur_tap == 8 && phase == 6);
            data_expected = 1'($urandom_range(0, 1));
            data_sample   = bad ? ~data_expected : data_expected;
            ->en_edge;
         end
         clk__enable = en_toggle ? ~clk__enable : 1'b1;
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(en_edge);
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 2000 && !done; i++) @(en_edge);
   endtask

   task automatic check_log(input string tag, input int exp_final);
      int v;
      chk({tag, "_loads"}, load_log.size(), MAX_TAP + 2);
      for (int i = 0; i <= MAX_TAP; i++) begin
         v = (i < load_log.size()) ? load_log[i] : -1;
         chk($sformatf("%s_load%0d", tag, i), v, i);
      end
      v = (load_log.size() > MAX_TAP + 1) ? load_log[MAX_TAP + 1] : -1;
      chk({tag, "_final_load"}, v, exp_final);
      chk({tag, "_single_op"}, dbl_op, 0);
   endtask

   task automatic run_sweep(input string tag, input logic [15:0] mask, input bit split,
                            input bit toggle, input int exp_res, input int exp_len,
                            input bit exp_succ);
      int cnt0;
      pass_mask  = mask;
      split_mode = split;
      en_toggle  = toggle;
      load_log.delete();
      dbl_op  = 1'b0;
      prev_op = 1'b0;
      pulse_start();
      cnt0 = en_cnt;
      wait_done();
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_latency"}, en_cnt - cnt0 + 1, LAT);
      chk({tag, "_success"}, success, exp_succ);
      chk({tag, "_result_tap"}, result_tap, exp_res);
      chk({tag, "_window"}, window_length, exp_len);
      chk({tag, "_op_idle"}, dcfg.op, 0);
      check_log(tag, exp_res);
      en_toggle  = 1'b0;
      split_mode = 1'b0;
   endtask

   initial begin
      int cnt0;
      // Reset state
      #12;
      chk("rst_op", dcfg.op, 0);
      chk("rst_value", dcfg.value, 0);
      chk("rst_select", dcfg.select, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_success", success, 0);
      chk("rst_result", result_tap, 0);
      chk("rst_window", window_length, 0);
      #1 reset_n = 1'b1;
      @(en_edge);

      // Main sweeps
      run_sweep("win5_10", 16'h07E0, 1'b0, 1'b0, 7, 6, 1'b1);
      run_sweep("tie",     16'h0E1C, 1'b0, 1'b0, 3, 3, 1'b1);
      run_sweep("short",   16'h0006, 1'b0, 1'b0, 0, 2, 1'b0);
      run_sweep("all",     16'hFFFF, 1'b0, 1'b0, 7, 16, 1'b1);
      run_sweep("split8",  16'hFFFF, 1'b1, 1'b0, 3, 8, 1'b1);
      run_sweep("gated",   16'h07E0, 1'b0, 1'b1, 7, 6, 1'b1);

      // Asynchronous reset during DWELL of tap 6
      pass_mask = 16'h07E0;
      load_log.delete();
      pulse_start();
      for (int i = 0; i < 2000 && !(cur_tap == 6 && phase == 4); i++) @(en_edge);
      chk("arst_reached_tap", cur_tap, 6);
      chk("arst_busy_before", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_op", dcfg.op, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_value", dcfg.value, 0);
      @(posedge clk);
      #3 reset_n = 1'b1;
      prev_op = 1'b0;
      dbl_op  = 1'b0;

      // Restart sweeps from tap 0; a start while busy is ignored
      load_log.delete();
      pulse_start();
      cnt0 = en_cnt;
      for (int i = 0; i < 2000 && load_log.size() < 4; i++) @(en_edge);
      chk("restart_first_tap", (load_log.size() > 0) ? load_log[0] : -1, 0);
      chk("restart_busy", busy, 1);
      pulse_start();
      wait_done();
      chk("restart_done", done, 1);
      chk("restart_latency", en_cnt - cnt0 + 1, LAT);
      chk("restart_result", result_tap, 7);
      chk("restart_window", window_length, 6);
      check_log("restart", 7);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
